fifo_sync_flags: RTL and testbench

- Single-clock, parametrised FIFO for same-domain buffering where a clock-crossing FIFO is unnecessary.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and consumer in one clock domain, e.g. packet staging ahead of a serialiser.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_sync_flags.sv | 104 ++++++++++
 tb/tb_fifo_sync_flags.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO mode constants and sizing helper
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - depth x width register array, sync write port, async read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 8,
    localparam int aw   = clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    // No reset: contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with thresholds, count, sticky errors, FWFT option
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 8,
    parameter int af_level = 6,
    parameter int ae_level = 2,
    parameter int fwft     = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    input  logic [width-1:0]      data_in,
    output logic [width-1:0]      data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [clog2(depth):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int aw = clog2(depth);
    localparam int pw = aw + 1;
    localparam logic [pw-1:0] af_lvl = pw'(af_level);
    localparam logic [pw-1:0] ae_lvl = pw'(ae_level);

    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic [pw-1:0]    wr_ptr_nxt;
    logic [pw-1:0]    rd_ptr_nxt;
    logic [pw-1:0]    count_nxt;
    logic             wr_ok;
    logic             rd_ok;
    logic [width-1:0] mem_rdata;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    assign wr_ptr_nxt = wr_ptr + {{aw{1'b0}}, wr_ok};
    assign rd_ptr_nxt = rd_ptr + {{aw{1'b0}}, rd_ok};
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= (wr_ptr_nxt == rd_ptr_nxt);
            full         <= (wr_ptr_nxt[aw-1:0] == rd_ptr_nxt[aw-1:0]) &&
                            (wr_ptr_nxt[aw] != rd_ptr_nxt[aw]);
            almost_full  <= (count_nxt >= af_lvl);
            almost_empty <= (count_nxt <= ae_lvl);
            // A fresh error on the clearing edge keeps the flag set.
            overflow     <= (wr & ~wr_ok) | (overflow & ~clr_err);
            underflow    <= (rd & ~rd_ok) | (underflow & ~clr_err);
        end
    end

    fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[aw-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[aw-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (fwft == FIFO_FWFT) begin : g_fwft
            // Head word shown directly; forced to zero while nothing is stored.
            assign data_out = empty ? '0 : mem_rdata;
        end else begin : g_std
            logic [width-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem_rdata;
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - randomized and directed self-checking bench for fifo_sync_flags
module tb_fifo_sync_flags;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] dout_s, dout_f;
    logic       full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [3:0] count_s;
    logic [2:0] count_f;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(.width(8), .depth(8), .af_level(6), .ae_level(2), .fwft(FIFO_STD)) u_std (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .clr_err(clr_err), .data_in(data_in),
        .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
        .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(udf_s)
    );

    fifo_sync_flags #(.width(8), .depth(4), .af_level(3), .ae_level(1), .fwft(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .clr_err(clr_err), .data_in(data_in),
        .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
        .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f)
    );

    // Reference model: circular buffer with head index and occupancy per instance.
    int         dep [2] = '{8, 4};
    int         afl [2] = '{6, 3};
    int         ael [2] = '{2, 1};
    logic [7:0] mbuf [2][8];
    int         head [2];
    int         cnt [2];
    logic [7:0] m_dout [2];
    bit         m_ovf [2];
    bit         m_udf [2];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            head[i] = 0;
            cnt[i] = 0;
            m_dout[i] = '0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit rok;
            bit wok;
            rok = rd && (cnt[i] != 0);
            wok = wr && ((cnt[i] != dep[i]) || rok);
            if (rok) begin
                m_dout[i] = mbuf[i][head[i]];
                head[i] = (head[i] + 1) % dep[i];
                cnt[i] = cnt[i] - 1;
            end
            if (wok) begin
                mbuf[i][(head[i] + cnt[i]) % dep[i]] = data_in;
                cnt[i] = cnt[i] + 1;
            end
            m_ovf[i] = (wr && !wok) || (m_ovf[i] && !clr_err);
            m_udf[i] = (rd && !rok) || (m_udf[i] && !clr_err);
        end
    endtask

    task automatic compare();
        chk("s_count", int'(count_s), cnt[0]);
        chk("s_empty", int'(empty_s), int'(cnt[0] == 0));
        chk("s_full", int'(full_s), int'(cnt[0] == dep[0]));
        chk("s_almost_full", int'(af_s), int'(cnt[0] >= afl[0]));
        chk("s_almost_empty", int'(ae_s), int'(cnt[0] <= ael[0]));
        chk("s_overflow", int'(ovf_s), int'(m_ovf[0]));
        chk("s_underflow", int'(udf_s), int'(m_udf[0]));
        chk("s_data_out", int'(dout_s), int'(m_dout[0]));
        chk("f_count", int'(count_f), cnt[1]);
        chk("f_empty", int'(empty_f), int'(cnt[1] == 0));
        chk("f_full", int'(full_f), int'(cnt[1] == dep[1]));
        chk("f_almost_full", int'(af_f), int'(cnt[1] >= afl[1]));
        chk("f_almost_empty", int'(ae_f), int'(cnt[1] <= ael[1]));
        chk("f_overflow", int'(ovf_f), int'(m_ovf[1]));
        chk("f_underflow", int'(udf_f), int'(m_udf[1]));
        if (cnt[1] != 0) begin
            chk("f_data_out", int'(dout_f), int'(mbuf[1][head[1]]));
        end
    endtask

    task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c = 1'b0);
        wr = w;
        rd = r;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare();
        chk("rst_empty", int'(empty_s), 1);
        chk("rst_ae", int'(ae_s), 1);
        chk("rst_dout", int'(dout_s), 0);

        // Three writes then three pops, standard read latency
        cyc(1, 0, 8'd10);
        chk("lit_cnt1", int'(count_s), 1);
        chk("lit_empty_fell", int'(empty_s), 0);
        cyc(1, 0, 8'd20);
        chk("lit_cnt2", int'(count_s), 2);
        cyc(1, 0, 8'd30);
        chk("lit_cnt3", int'(count_s), 3);
        cyc(0, 1, 8'd0);
        chk("lit_pop10", int'(dout_s), 10);
        cyc(0, 1, 8'd0);
        chk("lit_pop20", int'(dout_s), 20);
        cyc(0, 1, 8'd0);
        chk("lit_pop30", int'(dout_s), 30);
        chk("lit_empty_after", int'(empty_s), 1);
        chk("lit_no_udf", int'(udf_s), 0);

        // Fill to full, reject ninth write, drain in order
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 8'(40 + 10 * k));
            if (k == 4) chk("lit_af_low_at5", int'(af_s), 0);
            if (k == 5) chk("lit_af_at6", int'(af_s), 1);
            if (k == 6) chk("lit_not_full_at7", int'(full_s), 0);
        end
        chk("lit_full_at8", int'(full_s), 1);
        cyc(1, 0, 8'd120);
        chk("lit_ovf", int'(ovf_s), 1);
        chk("lit_cnt_stays8", int'(count_s), 8);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 8'd0);
            chk("lit_drain", int'(dout_s), 40 + 10 * k);
        end

        // Full with simultaneous write and read
        for (int k = 1; k <= 8; k++) cyc(1, 0, 8'(k));
        cyc(1, 1, 8'd55);
        chk("lit_swap_cnt", int'(count_s), 8);
        chk("lit_swap_pop", int'(dout_s), 1);
        for (int k = 0; k < 8; k++) cyc(0, 1, 8'd0);
        chk("lit_swap_last", int'(dout_s), 55);

        // Read on empty with a write
        cyc(1, 1, 8'd77);
        chk("lit_empty_rw_udf", int'(udf_s), 1);
        chk("lit_empty_rw_cnt", int'(count_s), 1);
        cyc(0, 1, 8'd0);
        chk("lit_77", int'(dout_s), 77);

        // FWFT: word visible when empty falls, no read needed
        cyc(1, 0, 8'hA5);
        chk("lit_fwft_dout", int'(dout_f), 8'hA5);
        chk("lit_fwft_empty", int'(empty_f), 0);
        cyc(0, 1, 8'd0);
        chk("lit_fwft_empty_after", int'(empty_f), 1);

        // Error clear, then clear racing a new rejected write
        cyc(0, 0, 8'd0, 1'b1);
        chk("lit_clr_ovf", int'(ovf_s), 0);
        chk("lit_clr_udf", int'(udf_s), 0);
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'(k));
        cyc(1, 0, 8'd99, 1'b1);
        chk("lit_set_wins", int'(ovf_s), 1);
        for (int k = 0; k < 8; k++) cyc(0, 1, 8'd0);

        // Write/read pairs wrap both pointer sets
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 8'(200 + k));
            cyc(0, 1, 8'd0);
            chk("lit_wrap", int'(dout_s), 200 + k);
        end

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                8'($urandom), ($urandom_range(0, 99) < 4));
        end

        // Asynchronous reset with five entries stored
        for (int k = 0; k < 8; k++) cyc(0, 1, 8'd0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 8'(k + 1));
        chk("lit_cnt5", int'(count_s), 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", int'(count_s), 0);
        chk("arst_empty", int'(empty_s), 1);
        chk("arst_af", int'(af_s), 0);
        chk("arst_ovf", int'(ovf_s), 0);
        chk("arst_udf", int'(udf_s), 0);
        chk("arst_dout", int'(dout_s), 0);
        chk("arst_f_empty", int'(empty_f), 1);
        chk("arst_f_count", int'(count_f), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();
        cyc(1, 0, 8'h3C);
        cyc(0, 1, 8'd0);
        chk("post_rst_dout", int'(dout_s), 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
